// File: rtl/bcd_scan_controller.sv
// Three-digit decimal display front end: binary-to-BCD repeated-subtraction
// converter with atomic commit, plus a free-running dwell-timed digit scanner.
module bcd_scan_controller #(
    parameter int unsigned DWELL_CYCLES  = 10,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       busy,
    output logic [3:0] digit,
    output logic [1:0] digit_place,
    output logic       digit_blank,
    output logic       digit_strobe
);

    localparam int unsigned CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HUND   = 2'd1,
        TENS   = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t     state, state_n;
    logic [7:0] rem, rem_n;
    logic [1:0] hc, hc_n;
    logic [3:0] tc, tc_n;
    logic       commit_c;

    logic [1:0] disp_h;
    logic [3:0] disp_t;
    logic [3:0] disp_o;

    logic [CNT_W-1:0] cnt;
    logic             advance_c;
    logic [1:0]       place_n;
    logic [3:0]       digit_n;
    logic             blank_n;

    // Conversion FSM state and working registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rem      <= '0;
            hc       <= '0;
            tc       <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            rem      <= rem_n;
            hc       <= hc_n;
            tc       <= tc_n;
            in_ready <= (state_n == IDLE);
            busy     <= (state_n != IDLE);
        end
    end

    always_comb begin
        state_n  = state;
        rem_n    = rem;
        hc_n     = hc;
        tc_n     = tc;
        commit_c = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    rem_n   = in_data;
                    hc_n    = '0;
                    tc_n    = '0;
                    state_n = HUND;
                end
            end
            HUND: begin
                if (rem >= 8'd100) begin
                    rem_n = rem - 8'd100;
                    hc_n  = hc + 2'd1;
                end else begin
                    state_n = TENS;
                end
            end
            TENS: begin
                if (rem >= 8'd10) begin
                    rem_n = rem - 8'd10;
                    tc_n  = tc + 4'd1;
                end else begin
                    state_n = COMMIT;
                end
            end
            COMMIT: begin
                commit_c = 1'b1;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Display registers change only on the commit edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            disp_h <= '0;
            disp_t <= '0;
            disp_o <= '0;
        end else if (commit_c) begin
            disp_h <= hc;
            disp_t <= tc;
            disp_o <= rem[3:0];
        end
    end

    // Scanner: next place, and its digit/blank taken from pre-commit display regs
    assign advance_c = (cnt == CNT_W'(DWELL_CYCLES - 1));

    always_comb begin
        place_n = 2'd2;
        digit_n = 4'd0;
        blank_n = 1'b0;
        case (digit_place)
            2'd2:    place_n = 2'd1;
            2'd1:    place_n = 2'd0;
            default: place_n = 2'd2;
        endcase
        case (place_n)
            2'd2: begin
                digit_n = 4'(disp_h);
                blank_n = BLANK_LEADING && (disp_h == 2'd0);
            end
            2'd1: begin
                digit_n = disp_t;
                blank_n = BLANK_LEADING && (disp_h == 2'd0) && (disp_t == 4'd0);
            end
            default: begin
                digit_n = disp_o;
                blank_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            digit_place  <= 2'd2;
            digit        <= 4'd0;
            digit_blank  <= BLANK_LEADING;
            digit_strobe <= 1'b0;
        end else begin
            digit_strobe <= advance_c;
            if (advance_c) begin
                cnt         <= '0;
                digit_place <= place_n;
                digit       <= digit_n;
                digit_blank <= blank_n;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bcd_scan_controller.sv
// Directed bench for bcd_scan_controller: three instances (default, no
// leading-zero blanking, single-cycle dwell) driven by shared stimulus.
module tb_bcd_scan_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;

    logic       in_ready, busy, digit_blank, digit_strobe;
    logic [3:0] digit;
    logic [1:0] digit_place;

    logic       in_ready_nb, busy_nb, blank_nb, strobe_nb;
    logic [3:0] digit_nb;
    logic [1:0] place_nb;

    logic       in_ready_d1, busy_d1, blank_d1, strobe_d1;
    logic [3:0] digit_d1;
    logic [1:0] place_d1;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    bcd_scan_controller #(.DWELL_CYCLES(10), .BLANK_LEADING(1'b1)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .busy(busy), .digit(digit), .digit_place(digit_place),
        .digit_blank(digit_blank), .digit_strobe(digit_strobe)
    );

    bcd_scan_controller #(.DWELL_CYCLES(10), .BLANK_LEADING(1'b0)) dut_nb (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_nb), .busy(busy_nb), .digit(digit_nb), .digit_place(place_nb),
        .digit_blank(blank_nb), .digit_strobe(strobe_nb)
    );

    bcd_scan_controller #(.DWELL_CYCLES(1), .BLANK_LEADING(1'b1)) dut_d1 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_d1), .busy(busy_d1), .digit(digit_d1), .digit_place(place_d1),
        .digit_blank(blank_d1), .digit_strobe(strobe_d1)
    );

    // Record digit/blank for each place over the next three scanner advances
    task automatic capture(output logic [11:0] dg, output logic [2:0] bl,
                           output logic [11:0] dgn, output logic [2:0] bln,
                           output logic ok);
        int seen = 0;
        int p;
        dg = '0; bl = '0; dgn = '0; bln = '0;
        for (int k = 0; k < 40 && seen < 3; k++) begin
            @(posedge clock); #1;
            if (digit_strobe) begin
                p = int'(digit_place);
                dg[p*4 +: 4]  = digit;
                bl[p]         = digit_blank;
                dgn[p*4 +: 4] = digit_nb;
                bln[p]        = blank_nb;
                seen++;
            end
        end
        ok = (seen == 3);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_handshake ready=%b busy=%b want 1/0", in_ready, busy);
        end
        checks++;
        if (digit_place !== 2'd2 || digit !== 4'd0 || digit_blank !== 1'b1 || digit_strobe !== 1'b0) begin
            errors++; $display("FAIL reset_scan place=%0d digit=%0d blank=%b strobe=%b want 2/0/1/0",
                               digit_place, digit, digit_blank, digit_strobe);
        end
        checks++;
        if (blank_nb !== 1'b0 || in_ready_nb !== 1'b1 || busy_nb !== 1'b0) begin
            errors++; $display("FAIL reset_noblank blank=%b ready=%b busy=%b want 0/1/0", blank_nb, in_ready_nb, busy_nb);
        end
        checks++;
        if (place_d1 !== 2'd2 || strobe_d1 !== 1'b0 || in_ready_d1 !== 1'b1 || busy_d1 !== 1'b0) begin
            errors++; $display("FAIL reset_dwell1 place=%0d strobe=%b ready=%b busy=%b want 2/0/1/0",
                               place_d1, strobe_d1, in_ready_d1, busy_d1);
        end
        @(posedge clock); @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_scan();
        logic [1:0] ep, ep1;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clock); #1;
            ep = (i < 10) ? 2'd2 : (i < 20) ? 2'd1 : (i < 30) ? 2'd0 : 2'd2;
            checks++;
            if (digit_strobe !== (i % 10 == 0) || digit_place !== ep) begin
                errors++; $display("FAIL scan_step i=%0d strobe=%b place=%0d want %b/%0d",
                                   i, digit_strobe, digit_place, (i % 10 == 0), ep);
            end
            ep1 = 2'(2 - (i % 3));
            checks++;
            if (strobe_d1 !== 1'b1 || place_d1 !== ep1) begin
                errors++; $display("FAIL dwell1_step i=%0d strobe=%b place=%0d want 1/%0d", i, strobe_d1, place_d1, ep1);
            end
        end
        checks++;
        if (strobe_nb !== 1'b1 || place_nb !== 2'd2) begin
            errors++; $display("FAIL scan_noblank strobe=%b place=%0d want 1/2", strobe_nb, place_nb);
        end
    endtask

    task automatic test_255();
        int n = 1;
        logic [11:0] dg, dgn;
        logic [2:0]  bl, bln;
        logic        ok;
        in_valid = 1'b1; in_data = 8'd255;
        @(posedge clock); #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL c255_accept ready=%b busy=%b want 0/1", in_ready, busy);
        end
        for (int k = 0; k < 20; k++) begin
            @(posedge clock); #1;
            if (in_ready) break;
            n++;
        end
        checks++;
        if (n != 10 || in_ready !== 1'b1) begin
            errors++; $display("FAIL c255_latency busy_cycles=%0d ready=%b want 10/1", n, in_ready);
        end
        capture(dg, bl, dgn, bln, ok);
        checks++;
        if (!ok || dg !== 12'h255 || bl !== 3'b000) begin
            errors++; $display("FAIL c255_display ok=%b digits=%h blank=%b want 1/255/000", ok, dg, bl);
        end
    endtask

    task automatic test_7();
        int n = 1;
        logic [11:0] dg, dgn;
        logic [2:0]  bl, bln;
        logic        ok;
        logic [3:0]  ed;
        logic        eb;
        in_valid = 1'b1; in_data = 8'd7;
        @(posedge clock); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clock); #1;
            if (in_ready) break;
            n++;
        end
        checks++;
        if (n != 3 || in_ready !== 1'b1) begin
            errors++; $display("FAIL c7_latency busy_cycles=%0d ready=%b want 3/1", n, in_ready);
        end
        // commit edge coincided with a dwell-1 advance: old value 2/5/5 still shown
        case (place_d1)
            2'd2:    ed = 4'd2;
            default: ed = 4'd5;
        endcase
        checks++;
        if (digit_d1 !== ed || blank_d1 !== 1'b0) begin
            errors++; $display("FAIL c7_same_edge place=%0d digit=%0d blank=%b want %0d/0", place_d1, digit_d1, blank_d1, ed);
        end
        @(posedge clock); #1;
        ed = (place_d1 == 2'd0) ? 4'd7 : 4'd0;
        eb = (place_d1 != 2'd0);
        checks++;
        if (digit_d1 !== ed || blank_d1 !== eb) begin
            errors++; $display("FAIL c7_next_advance place=%0d digit=%0d blank=%b want %0d/%b", place_d1, digit_d1, blank_d1, ed, eb);
        end
        capture(dg, bl, dgn, bln, ok);
        checks++;
        if (!ok || dg !== 12'h007 || bl !== 3'b110) begin
            errors++; $display("FAIL c7_display ok=%b digits=%h blank=%b want 1/007/110", ok, dg, bl);
        end
        checks++;
        if (dgn !== 12'h007 || bln !== 3'b000) begin
            errors++; $display("FAIL c7_noblank digits=%h blank=%b want 007/000", dgn, bln);
        end
    endtask

    task automatic test_back_to_back();
        int n = 1;
        logic [11:0] dg, dgn;
        logic [2:0]  bl, bln;
        logic        ok;
        in_valid = 1'b1; in_data = 8'd100;
        @(posedge clock); #1;
        in_data = 8'd55;
        @(posedge clock); #1;
        @(posedge clock); #1;
        in_data = 8'd9;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_busy_e2 ready=%b want 0", in_ready);
        end
        @(posedge clock); #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_busy_e3 ready=%b want 0", in_ready);
        end
        @(posedge clock); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_ready_after_commit ready=%b want 1", in_ready);
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_second_accept ready=%b want 0", in_ready);
        end
        for (int k = 0; k < 20; k++) begin
            @(posedge clock); #1;
            if (in_ready) break;
            n++;
        end
        checks++;
        if (n != 3 || in_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_second_latency busy_cycles=%0d ready=%b want 3/1", n, in_ready);
        end
        capture(dg, bl, dgn, bln, ok);
        checks++;
        if (!ok || dg !== 12'h009 || bl !== 3'b110) begin
            errors++; $display("FAIL b2b_display ok=%b digits=%h blank=%b want 1/009/110", ok, dg, bl);
        end
        checks++;
        if (dgn !== 12'h009 || bln !== 3'b000) begin
            errors++; $display("FAIL b2b_noblank digits=%h blank=%b want 009/000", dgn, bln);
        end
    endtask

    task automatic test_reset_mid();
        int n = 1;
        logic [11:0] dg, dgn;
        logic [2:0]  bl, bln;
        logic        ok;
        in_valid = 1'b1; in_data = 8'd200;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(posedge clock); #2;
        reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || digit_place !== 2'd2 || digit !== 4'd0 ||
            digit_blank !== 1'b1 || digit_strobe !== 1'b0) begin
            errors++; $display("FAIL midreset_async ready=%b busy=%b place=%0d digit=%0d blank=%b strobe=%b",
                               in_ready, busy, digit_place, digit, digit_blank, digit_strobe);
        end
        @(posedge clock); @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        capture(dg, bl, dgn, bln, ok);
        checks++;
        if (!ok || dg !== 12'h000 || bl !== 3'b110 || in_ready !== 1'b1) begin
            errors++; $display("FAIL midreset_no_commit ok=%b digits=%h blank=%b ready=%b want 1/000/110/1",
                               ok, dg, bl, in_ready);
        end
        in_valid = 1'b1; in_data = 8'd200;
        @(posedge clock); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clock); #1;
            if (in_ready) break;
            n++;
        end
        checks++;
        if (n != 5 || in_ready !== 1'b1) begin
            errors++; $display("FAIL c200_latency busy_cycles=%0d ready=%b want 5/1", n, in_ready);
        end
        capture(dg, bl, dgn, bln, ok);
        checks++;
        if (!ok || dg !== 12'h200 || bl !== 3'b000 || dgn !== 12'h200 || bln !== 3'b000) begin
            errors++; $display("FAIL c200_display ok=%b digits=%h blank=%b nb=%h/%b want 200/000",
                               ok, dg, bl, dgn, bln);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_255();
        test_7();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
